// File: rtl/pmem_burst_responder_if.sv
// Bus bundle between the cache-side line port (pmem_*) and the DRAM-side burst port (burst_*).
// slave = the burst responder; master = the cache/DRAM environment around it.
interface pmem_burst_responder_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [ADDR_W-1:0] burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/pmem_burst_responder.sv
// Turns cache line reads/write-backs into fixed BEATS-beat bursts and pulses pmem_resp per line.
// Optional macro CRITICAL_WORD_FIRST_EN: read bursts start at the beat holding pmem_address.
module pmem_burst_responder #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  pmem_burst_responder_if.slave  bus
);
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BOFF_W = $clog2(BEAT_W / 8);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  beat_reg;
  logic [CNT_W-1:0]  last_beat_reg;
  logic [LINE_W-1:0] wline_reg;
  logic [LINE_W-1:0] rline_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rd_reg;
  logic              wr_reg;
  logic              resp_reg;
  logic [BEAT_W-1:0] wdata_reg;

  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_first;
  logic [CNT_W-1:0]  beat_inc;
  logic [BEAT_W-1:0] wslot [BEATS];

  assign line_addr = {bus.pmem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign beat_inc  = beat_reg + CNT_W'(1);

`ifdef CRITICAL_WORD_FIRST_EN
  // Start at the requested beat; the counter wraps past BEATS-1 and the burst ends one slot before it.
  assign rd_first = bus.pmem_address[OFF_W-1:BOFF_W];
  assign rd_addr  = {bus.pmem_address[ADDR_W-1:BOFF_W], {BOFF_W{1'b0}}};
`else
  assign rd_first = '0;
  assign rd_addr  = line_addr;
`endif

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_wslot
    assign wslot[gi] = wline_reg[gi*BEAT_W +: BEAT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      last_beat_reg <= '0;
      wline_reg     <= '0;
      rline_reg     <= '0;
      addr_reg      <= '0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      resp_reg      <= 1'b0;
      wdata_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A write-back takes priority over a fill presented in the same cycle.
          if (bus.pmem_write) begin
            wline_reg     <= bus.pmem_wdata;
            addr_reg      <= line_addr;
            beat_reg      <= '0;
            last_beat_reg <= CNT_W'(BEATS - 1);
            wdata_reg     <= bus.pmem_wdata[BEAT_W-1:0];
            wr_reg        <= 1'b1;
            state_reg     <= WR_BURST;
          end else if (bus.pmem_read) begin
            addr_reg      <= rd_addr;
            beat_reg      <= rd_first;
            last_beat_reg <= rd_first - CNT_W'(1);
            rd_reg        <= 1'b1;
            state_reg     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (bus.burst_resp) begin
            rline_reg[beat_reg*BEAT_W +: BEAT_W] <= bus.burst_rdata;
            if (beat_reg == last_beat_reg) begin
              rd_reg    <= 1'b0;
              resp_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              beat_reg <= beat_inc;
            end
          end
        end
        WR_BURST: begin
          if (bus.burst_resp) begin
            if (beat_reg == last_beat_reg) begin
              wr_reg    <= 1'b0;
              resp_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              beat_reg  <= beat_inc;
              wdata_reg <= wslot[beat_inc];
            end
          end
        end
        DONE: begin
          resp_reg  <= 1'b0;
          beat_reg  <= '0;
          wdata_reg <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pmem_rdata    = rline_reg;
  assign bus.pmem_resp     = resp_reg;
  assign bus.burst_address = addr_reg;
  assign bus.burst_read    = rd_reg;
  assign bus.burst_write   = wr_reg;
  assign bus.burst_wdata   = wdata_reg;
endmodule
